// File: rtl/dmem_responder_if.sv
// Data-memory bus between the CPU MEM stage (master) and the responder (slave).
interface dmem_responder_if;
   logic        MemRe_i;
   logic        MemWr_i;
   logic [31:0] Adr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        stall_o;
   logic        ack_o;
   logic        err_o;

   modport master (
      output MemRe_i, MemWr_i, Adr_i, data_i,
      input  data_o, stall_o, ack_o, err_o
   );

   modport slave (
      input  MemRe_i, MemWr_i, Adr_i, data_i,
      output data_o, stall_o, ack_o, err_o
   );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency 32-word data memory with pipeline stall, ack and error strobes.
//
// state | meaning
// IDLE  | waiting for a request; a request stalls the pipe combinationally
// BUSY  | access in flight; counter runs down to 1
// DONE  | one-cycle completion; ack_o (and err_o if illegal) asserted
module dmem_responder #(
   parameter int LATENCY = 4,
   parameter int DEPTH   = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   dmem_responder_if.slave bus
);

   localparam int IW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [3:0]    cnt;
   logic [31:0]   adr_q;
   logic [31:0]   wdata_q;
   logic          re_q;
   logic          we_q;
   logic [31:0]   rdata_q;
   logic          ack_q;
   logic          err_q;
   logic [31:0]   mem [DEPTH];

   logic          req;
   logic          enter_done;
   logic [31:0]   acc_adr;
   logic [31:0]   acc_wdata;
   logic          acc_re;
   logic          acc_we;
   logic          acc_illegal;
   logic [IW-1:0] acc_idx;

   assign req = bus.MemRe_i | bus.MemWr_i;

   // With LATENCY=1 the access completes on the same edge that would latch it,
   // so the completing access is taken from the live inputs in IDLE.
   always_comb begin
      acc_adr   = adr_q;
      acc_wdata = wdata_q;
      acc_re    = re_q;
      acc_we    = we_q;
      if (state == IDLE) begin
         acc_adr   = bus.Adr_i;
         acc_wdata = bus.data_i;
         acc_re    = bus.MemRe_i;
         acc_we    = bus.MemWr_i;
      end
   end

   assign acc_illegal = (acc_adr[1:0] != 2'b00) || (acc_adr[31:IW+2] != '0) ||
                        (acc_re && acc_we);
   assign acc_idx     = acc_adr[IW+1:2];

   assign enter_done = ((state == IDLE) && req && (LATENCY == 1)) ||
                       ((state == BUSY) && (cnt == 4'd1));

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         adr_q   <= 32'd0;
         wdata_q <= 32'd0;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
         rdata_q <= 32'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 32'd0;
         end
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  adr_q   <= bus.Adr_i;
                  wdata_q <= bus.data_i;
                  re_q    <= bus.MemRe_i;
                  we_q    <= bus.MemWr_i;
                  cnt     <= 4'(LATENCY - 1);
                  state   <= (LATENCY == 1) ? DONE : BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase

         if (enter_done) begin
            ack_q <= 1'b1;
            err_q <= acc_illegal;
            if (acc_illegal) begin
               rdata_q <= 32'd0;
            end else if (acc_we) begin
               mem[acc_idx] <= acc_wdata;
            end else begin
               rdata_q <= mem[acc_idx];
            end
         end
      end
   end

   // Reset cycles never stall, whatever the request lines are doing.
   assign bus.stall_o = rst_i && (((state == IDLE) && req) || (state == BUSY));
   assign bus.ack_o   = ack_q;
   assign bus.err_o   = err_q;
   assign bus.data_o  = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed-vector and randomized bench for dmem_responder at LATENCY=4 and LATENCY=1.
module tb_dmem_responder;

   localparam int LAT = 4;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;

   always #5 clk_i = ~clk_i;

   dmem_responder_if b4 ();
   dmem_responder_if b1 ();

   dmem_responder #(.LATENCY(LAT), .DEPTH(32)) dut4 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (b4.slave)
   );

   dmem_responder #(.LATENCY(1), .DEPTH(32)) dut1 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (b1.slave)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] model_mem [32];
   logic [31:0] model_data;

   typedef struct {
      logic        re;
      logic        we;
      logic [31:0] adr;
      logic [31:0] wd;
      logic        exp_err;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_access(input logic re, input logic we, input logic [31:0] adr,
                               input logic [31:0] wd, output logic err, output logic [31:0] data);
      err = (adr[1:0] != 2'b00) || (adr[31:7] != 25'd0) || (re && we);
      if (err) begin
         model_data = 32'd0;
      end else if (we) begin
         model_mem[adr[6:2]] = wd;
      end else begin
         model_data = model_mem[adr[6:2]];
      end
      data = model_data;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
      model_data = 32'd0;
   endtask

   // Drives a request at a negedge (cycle T) and checks every cycle through the ack.
   task automatic do_access(input string name, input logic re, input logic we,
                            input logic [31:0] adr, input logic [31:0] wd,
                            input logic exp_err, input logic [31:0] exp_data);
      @(negedge clk_i);
      b4.MemRe_i = re;
      b4.MemWr_i = we;
      b4.Adr_i   = adr;
      b4.data_i  = wd;
      for (int k = 0; k <= LAT; k++) begin
         if (k > 0) @(negedge clk_i);
         #2;
         chk({name, " stall"}, 32'(b4.stall_o), 32'(k < LAT));
         chk({name, " ack"}, 32'(b4.ack_o), 32'(k == LAT));
      end
      chk({name, " err"}, 32'(b4.err_o), 32'(exp_err));
      chk({name, " data"}, b4.data_o, exp_data);
   endtask

   task automatic idle4(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk_i);
         b4.MemRe_i = 1'b0;
         b4.MemWr_i = 1'b0;
         #2;
         chk("idle stall", 32'(b4.stall_o), 32'd0);
         chk("idle ack", 32'(b4.ack_o), 32'd0);
         chk("idle err", 32'(b4.err_o), 32'd0);
      end
   endtask

   initial begin
      logic        merr;
      logic [31:0] mdata;
      logic [31:0] radr;
      logic        rre;
      logic        rwe;
      logic [31:0] rwd;

      vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
      vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b1, 1'b0, 32'h0000_0012, 32'h0000_0000, 1'b1, 32'h0000_0000};
      vecs[3]  = '{1'b1, 1'b0, 32'h0000_0080, 32'h0000_0000, 1'b1, 32'h0000_0000};
      vecs[4]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h1111_1111, 1'b1, 32'h0000_0000};
      vecs[5]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
      vecs[6]  = '{1'b0, 1'b1, 32'h0000_007C, 32'h0BAD_F00D, 1'b0, 32'hDEAD_BEEF};
      vecs[7]  = '{1'b1, 1'b0, 32'h0000_007C, 32'h0000_0000, 1'b0, 32'h0BAD_F00D};
      vecs[8]  = '{1'b0, 1'b1, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
      vecs[9]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'h0000_0000};
      vecs[10] = '{1'b0, 1'b1, 32'h0000_0004, 32'hCAFE_0004, 1'b0, 32'h0000_0000};
      vecs[11] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
      vecs[12] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'hCAFE_0004};

      model_clear();

      // Reset with a request held: no stall allowed during reset.
      b4.MemRe_i = 1'b1; b4.MemWr_i = 1'b0; b4.Adr_i = 32'h10; b4.data_i = 32'd0;
      b1.MemRe_i = 1'b0; b1.MemWr_i = 1'b0; b1.Adr_i = 32'h0;  b1.data_i = 32'd0;
      @(negedge clk_i);
      @(negedge clk_i);
      #2;
      chk("rst stall", 32'(b4.stall_o), 32'd0);
      chk("rst ack", 32'(b4.ack_o), 32'd0);
      chk("rst err", 32'(b4.err_o), 32'd0);
      chk("rst data", b4.data_o, 32'd0);
      chk("rst1 ack", 32'(b1.ack_o), 32'd0);
      chk("rst1 data", b1.data_o, 32'd0);
      @(negedge clk_i);
      b4.MemRe_i = 1'b0;
      rst_i = 1'b1;
      idle4(2);

      for (int i = 0; i < 13; i++) begin
         model_access(vecs[i].re, vecs[i].we, vecs[i].adr, vecs[i].wd, merr, mdata);
         do_access($sformatf("vec%0d", i), vecs[i].re, vecs[i].we, vecs[i].adr,
                   vecs[i].wd, vecs[i].exp_err, vecs[i].exp_data);
      end
      idle4(3);

      // Reset two cycles into a write: the write must be lost and no ack seen.
      @(negedge clk_i);
      b4.MemRe_i = 1'b0; b4.MemWr_i = 1'b1; b4.Adr_i = 32'h1C; b4.data_i = 32'h1234_5678;
      #2 chk("abort T stall", 32'(b4.stall_o), 32'd1);
      @(negedge clk_i);
      #2 chk("abort T+1 stall", 32'(b4.stall_o), 32'd1);
      @(negedge clk_i);
      rst_i = 1'b0;
      b4.MemWr_i = 1'b0;
      #2 chk("abort T+2 stall", 32'(b4.stall_o), 32'd0);
      chk("abort T+2 ack", 32'(b4.ack_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      model_clear();
      idle4(4);
      do_access("post-rst rd 1C", 1'b1, 1'b0, 32'h1C, 32'd0, 1'b0, 32'h0000_0000);
      do_access("post-rst wr 10", 1'b0, 1'b1, 32'h10, 32'h5555_AAAA, 1'b0, 32'h0000_0000);
      model_mem[4] = 32'h5555_AAAA;

      // Request held across reset is taken as a fresh access once reset lifts.
      @(negedge clk_i);
      rst_i = 1'b0;
      b4.MemRe_i = 1'b1; b4.MemWr_i = 1'b0; b4.Adr_i = 32'h10;
      #2 chk("held rst stall", 32'(b4.stall_o), 32'd0);
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      model_clear();
      do_access("held rd 10", 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 32'h0000_0000);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 60; n++) begin
         radr = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
         case ($urandom_range(0, 9))
            0: radr[1:0] = 2'($urandom_range(1, 3));
            1: radr[31:7] = 25'($urandom_range(1, 255));
            default: ;
         endcase
         rre = 1'b0; rwe = 1'b0;
         case ($urandom_range(0, 9))
            0: begin rre = 1'b1; rwe = 1'b1; end
            1, 2, 3, 4: rwe = 1'b1;
            default: rre = 1'b1;
         endcase
         rwd = $urandom;
         model_access(rre, rwe, radr, rwd, merr, mdata);
         do_access($sformatf("rnd%0d", n), rre, rwe, radr, rwd, merr, mdata);
         if ($urandom_range(0, 3) == 0) idle4(1);
      end
      idle4(1);

      // LATENCY=1: stall and ack alternate on back-to-back reads.
      @(negedge clk_i);
      b1.MemWr_i = 1'b1; b1.Adr_i = 32'h4; b1.data_i = 32'hA5A5_0001;
      #2 chk("l1 wr stall", 32'(b1.stall_o), 32'd1);
      chk("l1 wr ack", 32'(b1.ack_o), 32'd0);
      @(negedge clk_i);
      #2 chk("l1 wr done stall", 32'(b1.stall_o), 32'd0);
      chk("l1 wr done ack", 32'(b1.ack_o), 32'd1);
      chk("l1 wr done err", 32'(b1.err_o), 32'd0);
      b1.MemWr_i = 1'b0;
      b1.MemRe_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         b1.Adr_i = 32'(i * 4);
         #2 chk($sformatf("l1 rd%0d stall", i), 32'(b1.stall_o), 32'd1);
         chk($sformatf("l1 rd%0d ack", i), 32'(b1.ack_o), 32'd0);
         @(negedge clk_i);
         #2 chk($sformatf("l1 rd%0d done stall", i), 32'(b1.stall_o), 32'd0);
         chk($sformatf("l1 rd%0d done ack", i), 32'(b1.ack_o), 32'd1);
         chk($sformatf("l1 rd%0d data", i), b1.data_o, (i == 1) ? 32'hA5A5_0001 : 32'd0);
      end
      @(negedge clk_i);
      b1.MemRe_i = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
